cskipa_pipe: RTL and testbench
==============================

# cskipa_pipe

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface. The WIDTH-bit operand pair is split into BLK-bit carry-skip blocks, and the blocks are distributed evenly over STAGES register stages, with the carry registered between stages. It is the sequential successor of the fixed 32-bit carry-skip adder in the adder-classification generator set, and sits between an operand source and a result sink that may apply backpressure.

## Interface
- WIDTH, 32: operand and sum width. Must be a multiple of BLK.
- BLK, 4: carry-skip block width in bits.
- STAGES, 4: number of pipeline stages. NB = WIDTH/BLK must be divisible by STAGES.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operand beat present.
- o_ready  output  1  adder can accept a beat this cycle.
- i_add_term1  input  WIDTH  operand A.
- i_add_term2  input  WIDTH  operand B.
- i_cin  input  1  carry in. Ignored when i_sub=1.
- i_sub  input  1  1: compute A−B; 0: compute A+B+cin.
- o_valid  output  1  result beat present.
- i_ready  input  1  sink accepts the result beat.
- o_sum  output  WIDTH  result, modulo 2^WIDTH.
- o_cout  output  1  carry out of the MSB block. For subtraction, 1 means no borrow.
- o_ovf  output  1  signed two's-complement overflow.

## Operation
- Effective operands: B' = i_sub ? ~B : B; c0 = i_sub ? 1 : i_cin.
- Block rule, for block k with carry-in c:
  - P_k = &(A_k ^ B'_k).
  - Block carry-out = P_k ? c : ripple carry-out.
  - Block sum = ripple sum of A_k, B'_k and c.
- Stage s handles blocks s·NB/STAGES … (s+1)·NB/STAGES−1.
- Each stage register holds:
  - valid bit;
  - carry out of the stage;
  - completed sum bits;
  - unconsumed upper operand bits (A and B', already skewed);
  - sign bits A[MSB] and B'[MSB], needed for overflow.
- o_cout = final-stage carry.
- o_ovf = (A[MSB]==B'[MSB]) && (o_sum[MSB]!=A[MSB]).
- Result equals A+B'+c0 exactly. The skip path must never change the arithmetic result; it only shortens the path.
- Flow control, per stage s:
  - adv_s = !v_s || adv_{s+1}.
  - Output-side term is i_ready.
  - o_ready = adv_0.
  - Stage s loads from stage s−1, or from the inputs for s=0, when adv_s.
  - v_s takes the upstream valid on load.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Input accepted only on i_valid && o_ready. Output consumed only on o_valid && i_ready.

## Timing
- Latency: exactly STAGES cycles from input acceptance to o_valid, when there is no stall.
- Throughput: one beat per cycle when i_ready is held at 1.
- STAGES=1: single register stage, latency 1.
- Reset: all v_s=0, o_valid=0, o_sum=0, o_cout=0, o_ovf=0.
  - o_ready=1 from the first edge after reset deassertion.
  - Assertion mid-operation discards all in-flight beats immediately (asynchronous).
- Stall: while o_valid && !i_ready, o_sum, o_cout and o_ovf hold stable.
  - o_ready falls only when every stage holds a valid beat.
- Full pipeline with i_ready=1 and i_valid=1: accept and emit in the same cycle; no bubble inserted.
- Back-to-back beats with alternating i_sub must not share a carry.
- Combinational path per stage: NB/STAGES blocks, each contributing one skip mux plus ripple into the first block.
- o_ready combinationally depends on i_ready, through the adv chain.

## Structure
- Package cskipa_pkg:
  - localparam functions nb(WIDTH,BLK) and bps(WIDTH,BLK,STAGES);
  - elaboration-time check function for legal WIDTH/BLK/STAGES combinations;
  - stage-register struct typedef (valid, carry, sum, operand remainder, sign bits).
- Sub-module cskip_block, BLK-parametrised:
  - inputs A, B, cin;
  - outputs sum, cout;
  - internally: ripple carry, propagate AND, skip mux.
- Top level: generate loops over stages and over blocks within each stage. Illegal parameters are a compile-time error.

## Test plan
- Reset, then A=0x0000_0001, B=0xFFFF_FFFF, cin=0, sub=0 -> 4 cycles later: o_sum=0, o_cout=1, o_ovf=0. This exercises full propagate/skip across all blocks.
- A=0x7FFF_FFFF, B=1, add -> o_sum=0x8000_0000, o_ovf=1, o_cout=0.
- A=5, B=7, sub=1 -> o_sum=0xFFFF_FFFE, o_cout=0 (borrow). Then A=7, B=5, sub=1 -> o_sum=2, o_cout=1.
- Stream 1000 random beats with random i_valid/i_ready, checked against a scoreboard model A+B'+c0:
  - zero loss or duplication;
  - outputs stable under stall;
  - o_ready=0 only when all 4 stages are full.
- Fill the pipeline, hold i_ready=0, assert i_rst_n=0 mid-cycle:
  - o_valid drops immediately, outputs 0;
  - after release the first accepted beat emerges alone after 4 cycles.
- Regression at WIDTH=16, BLK=2, STAGES=8 and at WIDTH=64, BLK=8, STAGES=1:
  - latencies 8 and 1;
  - 0xFFFF+1 -> sum 0, cout 1;
  - all-ones + 1 correct at 64 bits.

Source files
------------

// File: rtl/cskipa_pkg.sv
// cskipa_pkg: shared parameter helpers and stage-register header for cskipa_pipe
package cskipa_pkg;
  function automatic int nb(input int width, input int blk);
    return width / blk;
  endfunction
  function automatic int bps(input int width, input int blk, input int stages);
    return nb(width, blk) / stages;
  endfunction
  function automatic bit legal(input int width, input int blk, input int stages);
    return blk > 0 && stages > 0 && width >= blk && width % blk == 0 && nb(width, blk) % stages == 0;
  endfunction
  // Per-stage control fields; the sum/operand payload width varies per stage and lives beside it.
  typedef struct packed {
    logic v;
    logic c;
    logic sa;
    logic sb;
  } stage_hdr_t;
endpackage

// File: rtl/cskipa_pipe_cskip_block.sv
// cskip_block: one BLK-bit ripple block with a propagate-driven carry skip
module cskip_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] i_a,
  input  logic [BLK-1:0] i_b,
  input  logic           i_cin,
  output logic [BLK-1:0] o_sum,
  output logic           o_cout
);
  logic [BLK:0] w_c;
  logic         w_p;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < BLK; i++) begin : g_rip
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & w_c[i]);
  end
  // When every bit propagates the ripple carry equals cin, so the skip is arithmetic-neutral.
  assign w_p    = &(i_a ^ i_b);
  assign o_cout = w_p ? i_cin : w_c[BLK];
endmodule

// File: rtl/cskipa_pipe.sv
// cskipa_pipe: pipelined carry-skip adder/subtractor with valid/ready flow control
module cskipa_pipe
  import cskipa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  localparam int BPS = bps(WIDTH, BLK, STAGES);
  localparam int SW  = BPS * BLK;
  if (!legal(WIDTH, BLK, STAGES)) begin : g_bad
    $fatal(1, "cskipa_pipe: WIDTH must be a multiple of BLK and WIDTH/BLK a multiple of STAGES");
  end
  logic [WIDTH-1:0] w_b;
  logic [STAGES:0]  w_adv;
  stage_hdr_t       w_last;
  assign w_b           = i_sub ? ~i_add_term2 : i_add_term2;
  assign w_adv[STAGES] = i_ready;
  assign o_ready       = w_adv[0];
  // Stage payload layout: {B' remainder, A remainder at its own bit positions, completed sum bits}.
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * SW;
    localparam int HI = LO + SW;
    localparam int DW = 2 * WIDTH - HI;
    logic [2*WIDTH-LO-1:0] w_in;
    logic [2*WIDTH-LO-1:0] w_t;
    logic [DW-1:0]         w_nx;
    logic [BPS:0]          w_c;
    logic [SW-1:0]         w_s;
    stage_hdr_t            w_hin;
    logic [DW-1:0]         r_d;
    stage_hdr_t            r_h;
    if (s == 0) begin : g_src
      assign w_in  = {w_b, i_add_term1};
      assign w_hin = '{v: i_valid, c: i_sub | i_cin, sa: i_add_term1[WIDTH-1], sb: w_b[WIDTH-1]};
    end else begin : g_src
      assign w_in  = g_st[s-1].r_d;
      assign w_hin = g_st[s-1].r_h;
    end
    assign w_c[0] = w_hin.c;
    for (genvar k = 0; k < BPS; k++) begin : g_blk
      cskip_block #(.BLK(BLK)) u_blk (
        .i_a   (w_in[LO+k*BLK +: BLK]),
        .i_b   (w_in[WIDTH+k*BLK +: BLK]),
        .i_cin (w_c[k]),
        .o_sum (w_s[k*BLK +: BLK]),
        .o_cout(w_c[k+1])
      );
    end
    // Overwrite this stage's A slice with its sum, then drop the consumed B' slice.
    always_comb begin
      w_t        = w_in;
      w_t[HI-1:LO] = w_s;
    end
    assign w_nx     = DW'({w_t >> (WIDTH + SW), w_t[WIDTH-1:0]});
    assign w_adv[s] = !r_h.v || w_adv[s+1];
    // Stage register: loads whenever it is empty or its contents move on.
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        r_h <= '0;
        r_d <= '0;
      end else if (w_adv[s]) begin
        r_h <= '{v: w_hin.v, c: w_c[BPS], sa: w_hin.sa, sb: w_hin.sb};
        r_d <= w_nx;
      end
  end
  assign w_last  = g_st[STAGES-1].r_h;
  assign o_sum   = g_st[STAGES-1].r_d;
  assign o_valid = w_last.v;
  assign o_cout  = w_last.c;
  assign o_ovf   = (w_last.sa == w_last.sb) && (o_sum[WIDTH-1] != w_last.sa);
endmodule

// File: tb/tb_cskipa_pipe.sv
// tb_cskipa_pipe: randomized scoreboard bench for cskipa_pipe plus two alternate geometries
module tb_cskipa_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        i_valid = 0, i_ready = 1, i_cin = 0, i_sub = 0;
  logic [31:0] i_a = 0, i_b = 0;
  logic        o_ready, o_valid, o_cout, o_ovf;
  logic [31:0] o_sum;
  logic        v16 = 0, r16, ov16, c16, f16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic        v64 = 0, r64, ov64, c64, f64, sub64 = 0;
  logic [63:0] a64 = 0, b64 = 0, s64;
  int checks = 0, errors = 0;
  logic [33:0] q[$];

  always #5 clk = ~clk;

  cskipa_pipe u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_add_term1(i_a), .i_add_term2(i_b), .i_cin(i_cin), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf)
  );
  cskipa_pipe #(.WIDTH(16), .BLK(2), .STAGES(8)) u_d16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(r16),
    .i_add_term1(a16), .i_add_term2(b16), .i_cin(1'b0), .i_sub(1'b0),
    .o_valid(ov16), .i_ready(1'b1), .o_sum(s16), .o_cout(c16), .o_ovf(f16)
  );
  cskipa_pipe #(.WIDTH(64), .BLK(8), .STAGES(1)) u_d64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v64), .o_ready(r64),
    .i_add_term1(a64), .i_add_term2(b64), .i_cin(1'b0), .i_sub(sub64),
    .o_valid(ov64), .i_ready(1'b1), .o_sum(s64), .o_cout(c64), .o_ovf(f64)
  );

  function automatic logic [33:0] ref_add(input logic [31:0] a, b, input logic cin, sub);
    longint ua, ub, us, t;
    logic co;
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      us = ua - ub;
      co = ua >= ub;
      t  = longint'($signed(a)) - longint'($signed(b));
    end else begin
      us = ua + ub + longint'(cin);
      co = us > 64'sd4294967295;
      t  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    return {(t > 64'sd2147483647) || (t < -64'sd2147483648), co, us[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7, 0))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_single(input logic [31:0] a, b, input logic cin, sub,
                              output int lat, output logic [33:0] res);
    @(negedge clk);
    i_valid = 1; i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_ready = 1;
    @(posedge clk); #1;
    i_valid = 0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {o_ovf, o_cout, o_sum};
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o_valid !== 0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if ({o_ovf, o_cout, o_sum} !== 34'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {o_ovf, o_cout, o_sum}); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (o_ready !== 1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] va[4] = '{32'h1, 32'h7FFF_FFFF, 32'h5, 32'h7};
    logic [31:0] vb[4] = '{32'hFFFF_FFFF, 32'h1, 32'h7, 32'h5};
    logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [33:0] ve[4] = '{{2'b01, 32'h0}, {2'b10, 32'h8000_0000}, {2'b00, 32'hFFFF_FFFE}, {2'b01, 32'h2}};
    int lat;
    logic [33:0] res;
    for (int i = 0; i < 4; i++) begin
      drive_single(va[i], vb[i], 1'b0, vs[i], lat, res);
      checks++; if (lat != 4) begin errors++; $display("FAIL directed_latency[%0d] got %0d exp 4", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL directed_result[%0d] got %h exp %h", i, res, ve[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp[8];
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      i_ready = 1;
      if (c < 8) begin
        i_valid = 1; i_a = $urandom; i_b = $urandom; i_cin = 1; i_sub = c[0];
        exp[c] = ref_add(i_a, i_b, i_cin, i_sub);
      end else i_valid = 0;
      #1;
      checks++; if (o_ready !== 1) begin errors++; $display("FAIL b2b_ready cycle %0d got %b exp 1", c, o_ready); end
      @(posedge clk); #1;
      if (c >= 3 && c < 11) begin
        checks++;
        if (o_valid !== 1 || {o_ovf, o_cout, o_sum} !== exp[c-3]) begin
          errors++; $display("FAIL b2b_beat[%0d] got v=%b %h exp v=1 %h", c - 3, o_valid, {o_ovf, o_cout, o_sum}, exp[c-3]);
        end
      end
    end
    checks++; if (o_valid !== 0) begin errors++; $display("FAIL b2b_drain got %b exp 0", o_valid); end
  endtask

  task automatic test_stream();
    int sent = 0;
    logic stalled = 0;
    logic [33:0] held = 0, e;
    q.delete();
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() > 0); cyc++) begin
      @(negedge clk);
      if (sent < 1000 && $urandom_range(3, 0) != 0) begin
        i_valid = 1; i_a = pick(); i_b = pick(); i_cin = $urandom_range(1, 0); i_sub = $urandom_range(1, 0);
      end else i_valid = 0;
      i_ready = (sent >= 1000) ? 1'b1 : ($urandom_range(3, 0) != 0);
      #1;
      if (stalled) begin
        checks++;
        if (o_valid !== 1 || {o_ovf, o_cout, o_sum} !== held) begin
          errors++; $display("FAIL stall_hold cycle %0d got v=%b %h exp v=1 %h", cyc, o_valid, {o_ovf, o_cout, o_sum}, held);
        end
      end
      checks++;
      if (o_ready !== !(q.size() == 4 && !i_ready)) begin
        errors++; $display("FAIL stream_ready cycle %0d got %b exp %b", cyc, o_ready, !(q.size() == 4 && !i_ready));
      end
      if (o_valid === 1) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stream_dup cycle %0d got valid exp none in flight", cyc); end
        else if (i_ready) begin
          e = q.pop_front();
          if ({o_ovf, o_cout, o_sum} !== e) begin errors++; $display("FAIL stream_data cycle %0d got %h exp %h", cyc, {o_ovf, o_cout, o_sum}, e); end
        end
      end
      stalled = o_valid && !i_ready;
      held = {o_ovf, o_cout, o_sum};
      if (i_valid && o_ready) begin
        q.push_back(ref_add(i_a, i_b, i_cin, i_sub));
        sent++;
      end
    end
    i_valid = 0;
    checks++; if (sent != 1000 || q.size() != 0) begin errors++; $display("FAIL stream_loss got sent=%0d pending=%0d exp 1000/0", sent, q.size()); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [33:0] res;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_ready = 0; i_valid = 1; i_a = $urandom; i_b = $urandom; i_cin = 0; i_sub = 0;
    end
    @(negedge clk); i_valid = 0; #1;
    checks++; if (o_ready !== 0 || o_valid !== 1) begin errors++; $display("FAIL full_state got rdy=%b v=%b exp 0/1", o_ready, o_valid); end
    #1 rst_n = 0; #1;
    checks++; if (o_valid !== 0 || {o_ovf, o_cout, o_sum} !== 34'h0) begin errors++; $display("FAIL async_reset got v=%b %h exp 0", o_valid, {o_ovf, o_cout, o_sum}); end
    checks++; if (o_ready !== 1) begin errors++; $display("FAIL async_reset_ready got %b exp 1", o_ready); end
    @(negedge clk); rst_n = 1;
    drive_single(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, lat, res);
    checks++; if (lat != 4 || res !== ref_add(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0)) begin
      errors++; $display("FAIL post_reset_beat got lat=%0d %h exp lat=4 %h", lat, res, ref_add(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0));
    end
    @(posedge clk); #1;
    checks++; if (o_valid !== 0) begin errors++; $display("FAIL post_reset_alone got %b exp 0", o_valid); end
  endtask

  task automatic test_params();
    int lat;
    logic [64:0] e;
    @(negedge clk); v16 = 1; a16 = 16'hFFFF; b16 = 16'h1;
    @(posedge clk); #1; v16 = 0; lat = 1;
    while (!ov16 && lat < 30) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 8) begin errors++; $display("FAIL w16_latency got %0d exp 8", lat); end
    checks++; if ({c16, s16} !== 17'h1_0000) begin errors++; $display("FAIL w16_result got %h exp 10000", {c16, s16}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); v64 = 1;
      if (i == 0) begin a64 = '1; b64 = 64'h1; sub64 = 0; end
      else begin a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; sub64 = i[0]; end
      e = sub64 ? {a64 >= b64, a64 - b64} : {1'b0, a64} + {1'b0, b64};
      @(posedge clk); #1; v64 = 0; lat = 1;
      while (!ov64 && lat < 30) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 1) begin errors++; $display("FAIL w64_latency[%0d] got %0d exp 1", i, lat); end
      checks++; if ({c64, s64} !== e) begin errors++; $display("FAIL w64_result[%0d] got %h exp %h", i, {c64, s64}, e); end
    end
    checks++; if (f64 !== ((a64[63] == (sub64 ? ~b64[63] : b64[63])) && (s64[63] != a64[63]))) begin
      errors++; $display("FAIL w64_ovf got %b", f64);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
